freq_meter: RTL and testbench

- Measures the frequency of an external square-wave or tick signal by counting its rising edges over a fixed gate window of clk_in cycles.
- Complements the frequency divider: that block generates slow clocks, this block reads them back. Used for self-test of divider outputs and for measuring external inputs.
- Results are handed to downstream display or register logic with a single-cycle valid strobe.

---
 rtl/freq_meter.sv | 139 +++++++++++++
 tb/tb_freq_meter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clk_in cycles and reports the total with a valid strobe.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned GW          = 26,
    parameter int unsigned CW          = 24
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          sig_in,
    input  logic          start,
    input  logic          cont,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          valid,
    output logic          overflow
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_ONE  = GW'(1);
    localparam logic [GW-1:0] GATE_ZERO = '0;
    localparam logic [CW-1:0] EDGE_MAX  = '1;
    localparam logic [CW-1:0] EDGE_ONE  = CW'(1);
    localparam logic [CW-1:0] EDGE_ZERO = '0;

    state_t          state_r;
    logic            sync1_r;
    logic            sync2_r;
    logic            sync3_r;
    logic            rise_s;
    logic [GW-1:0]   gate_cnt_r;
    logic [CW-1:0]   edge_cnt_r;
    logic            sat_r;
    logic [CW-1:0]   edge_nxt_s;
    logic            sat_nxt_s;
    logic            last_s;
    logic            busy_r;
    logic            valid_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;

    // Two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~sync3_r;
    assign last_s = (gate_cnt_r == GATE_LAST);

    // Saturating edge total including a rise in the current cycle
    always_comb begin
        edge_nxt_s = edge_cnt_r;
        sat_nxt_s  = sat_r;
        if (rise_s) begin
            if (edge_cnt_r == EDGE_MAX) begin
                sat_nxt_s = 1'b1;
            end else begin
                edge_nxt_s = edge_cnt_r + EDGE_ONE;
            end
        end else begin
            edge_nxt_s = edge_cnt_r;
            sat_nxt_s  = sat_r;
        end
    end

    // Gate FSM, window counters and registered result outputs
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            gate_cnt_r <= GATE_ZERO;
            edge_cnt_r <= EDGE_ZERO;
            sat_r      <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            count_r    <= EDGE_ZERO;
            overflow_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start || cont) begin
                        state_r    <= GATE;
                        busy_r     <= 1'b1;
                        gate_cnt_r <= GATE_ZERO;
                        edge_cnt_r <= EDGE_ZERO;
                        sat_r      <= 1'b0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                GATE: begin
                    if (last_s) begin
                        count_r    <= edge_nxt_s;
                        overflow_r <= sat_nxt_s;
                        valid_r    <= 1'b1;
                        gate_cnt_r <= GATE_ZERO;
                        edge_cnt_r <= EDGE_ZERO;
                        sat_r      <= 1'b0;
                        // Continuous mode restarts with no dead cycle
                        if (cont) begin
                            state_r <= GATE;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        gate_cnt_r <= gate_cnt_r + GATE_ONE;
                        edge_cnt_r <= edge_nxt_s;
                        sat_r      <= sat_nxt_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign valid    = valid_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter: a 100-cycle-gate instance for
// timing/continuous/reset tests and a 600-cycle-gate instance for saturation.
module tb_freq_meter;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       sig_in;
    logic       start_a, start_b, cont_a, cont_b;
    logic       busy_a, valid_a, ovf_a;
    logic       busy_b, valid_b, ovf_b;
    logic [7:0] count_a, count_b;

    int errors = 0;
    int checks = 0;
    int period = 0;   // 0: held low, 1: held high, >=2: square wave period
    bit sel    = 1'b0; // 0: short-gate instance, 1: long-gate instance

    logic       o_busy, o_valid, o_ovf;
    logic [7:0] o_count;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_ovf   = sel ? ovf_b   : ovf_a;
    assign o_count = sel ? count_b : count_a;

    always #5 clk_in = ~clk_in;

    freq_meter #(.GATE_CYCLES(100), .GW(8), .CW(8)) dut (
        .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start_a),
        .cont(cont_a), .busy(busy_a), .count(count_a), .valid(valid_a),
        .overflow(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(600), .GW(10), .CW(8)) dut_sat (
        .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start_b),
        .cont(cont_b), .busy(busy_b), .count(count_b), .valid(valid_b),
        .overflow(ovf_b)
    );

    // Square-wave source, updated on the inactive edge
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (period == 0) sig_in = 1'b0;
            else if (period == 1) sig_in = 1'b1;
            else begin
                ph = (ph + 1) % period;
                sig_in = (ph < period / 2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // One start pulse on the selected instance, then check the result timing
    task automatic measure(input int exp_cnt, input int exp_ovf, input int gate);
        int n;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        tick;
        start_a = 1'b0;
        start_b = 1'b0;
        n = 1;
        while (n < gate + 10) begin
            if (o_valid) break;
            check("busy_win", o_busy, 1);
            tick;
            n++;
        end
        check("valid_lat", n, gate + 1);
        check("count", o_count, exp_cnt);
        check("overflow", o_ovf, exp_ovf);
        check("busy_end", o_busy, 0);
        tick;
        check("valid_once", o_valid, 0);
    endtask

    initial begin
        int vcnt;
        reset = 1'b0;
        start_a = 1'b0; start_b = 1'b0; cont_a = 1'b0; cont_b = 1'b0;
        repeat (3) tick;
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_busy_b", busy_b, 0);
        reset = 1'b1;
        repeat (2) tick;

        // Period 10 over a 100-cycle window
        period = 10;
        repeat (20) tick;
        measure(10, 0, 100);

        // Static high, then static low
        period = 1;
        repeat (5) tick;
        measure(0, 0, 100);
        period = 0;
        repeat (5) tick;
        measure(0, 0, 100);

        // 300 rises saturate an 8-bit count; then a clean 60
        sel = 1'b1;
        period = 2;
        repeat (5) tick;
        measure(255, 1, 600);
        period = 10;
        repeat (20) tick;
        measure(60, 0, 600);
        sel = 1'b0;

        // Continuous mode, cont dropped at gate cycle 40 of the fourth window
        period = 4;
        repeat (8) tick;
        cont_a = 1'b1;
        tick;
        for (int n = 1; n <= 420; n++) begin
            check("cont_busy", busy_a, (n <= 400) ? 1 : 0);
            check("cont_valid", valid_a,
                  (n == 101 || n == 201 || n == 301 || n == 401) ? 1 : 0);
            if (n == 101 || n == 201 || n == 301 || n == 401)
                check("cont_count", count_a, 25);
            if (n == 340) cont_a = 1'b0;
            tick;
        end

        // Async reset mid-gate clears outputs before the next edge
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (49) tick;
        check("pre_rst_busy", busy_a, 1);
        check("pre_rst_count", count_a, 25);
        reset = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_valid", valid_a, 0);
        check("arst_count", count_a, 0);
        check("arst_ovf", ovf_a, 0);
        tick;
        tick;
        reset = 1'b1;
        vcnt = 0;
        repeat (150) begin
            tick;
            if (valid_a) vcnt++;
        end
        check("no_valid_after_rst", vcnt, 0);
        check("idle_after_rst", busy_a, 0);
        period = 10;
        repeat (20) tick;
        measure(10, 0, 100);

        // Start while busy is ignored
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int n = 1; n <= 110; n++) begin
            check("rs_busy", busy_a, (n <= 100) ? 1 : 0);
            check("rs_valid", valid_a, (n == 101) ? 1 : 0);
            if (n == 101) check("rs_count", count_a, 10);
            start_a = (n == 50);
            tick;
        end
        start_a = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
